mux_n1_stream: RTL and testbench

- Parametrised N-channel, WIDTH-bit selector with a registered output. It is the successor to the single-bit 2:1 combinational mux used in the ALU datapath.
- Adds per-channel valid/ready handshakes, a one-entry output register and two modes:
  - manual select
  - round-robin scan that skips idle channels
- Feeds ALU operand and result staging, where several sources share one downstream port.

---
 rtl/mux_n1_stream_pkg.sv | 17 +
 rtl/mux_n1_stream_rr_pick.sv | 27 ++
 rtl/mux_n1_stream.sv | 91 +++++++++
 tb/tb_mux_n1_stream.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_n1_stream_pkg.sv
// Shared constants for the ALU-lab stream selector: mode encodings, default sizes
// and the small wrap helper used by the round-robin search.
package mux_n1_stream_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NCH   = 4;
    localparam int DEF_SEL_W = 2;

    // Inputs never exceed 2*n-2, so a single conditional subtract is enough.
    function automatic int wrap_idx(input int v, input int n);
        return (v >= n) ? v - n : v;
    endfunction

endpackage

// File: rtl/mux_n1_stream_rr_pick.sv
// Wrap-around first-set search: the lowest offset from ptr with a valid bit wins.
module mux_n1_stream_rr_pick
    import mux_n1_stream_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic [NCH-1:0]   valid,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] cand,
    output logic             any
);

    always_comb begin
        cand = '0;
        any  = |valid;
        // Walk offsets from farthest to nearest so the nearest valid channel is written last.
        for (int k = NCH - 1; k >= 0; k--) begin
            for (int c = 0; c < NCH; c++) begin
                if (valid[c] && (c == wrap_idx(int'(ptr) + k, NCH))) begin
                    cand = SEL_W'(c);
                end
            end
        end
    end

endmodule

// File: rtl/mux_n1_stream.sv
// N-channel valid/ready selector with a one-entry output register, manual or
// round-robin selection. out_valid states: EMPTY (0) | no word held; FULL (1) | word held.
module mux_n1_stream
    import mux_n1_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SEL_W-1:0]     out_ch
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_cand;
    logic             rr_any;
    logic [SEL_W-1:0] cand;
    logic             grant_valid;
    logic             space;
    logic             load;
    logic             sel_valid;
    logic [WIDTH-1:0] cand_data;

    mux_n1_stream_rr_pick #(
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .valid (in_valid),
        .ptr   (ptr),
        .cand  (rr_cand),
        .any   (rr_any)
    );

    always_comb begin
        sel_valid = 1'b0;
        cand_data = '0;
        in_ready  = '0;

        // A sel at or beyond NCH matches no channel and therefore never grants.
        for (int c = 0; c < NCH; c++) begin
            if (c == int'(sel)) sel_valid = in_valid[c];
        end

        if (mode == MODE_SCAN) begin
            cand        = rr_cand;
            grant_valid = rr_any;
        end else begin
            cand        = sel;
            grant_valid = sel_valid;
        end

        space = ~out_valid | out_ready;
        load  = !rst && space && grant_valid;

        for (int c = 0; c < NCH; c++) begin
            if (c == int'(cand)) begin
                cand_data   = in_data[c*WIDTH +: WIDTH];
                in_ready[c] = load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_data  <= cand_data;
            out_valid <= 1'b1;
            out_ch    <= cand;
            if (mode == MODE_SCAN) begin
                if (int'(cand) == NCH - 1) ptr <= '0;
                else                       ptr <= cand + SEL_W'(1);
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_n1_stream.sv
// Directed scenarios followed by randomized traffic, all checked against a
// cycle-level reference model of the selector's rules.
module tb_mux_n1_stream;
    import mux_n1_stream_pkg::*;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SEL_W-1:0]     out_ch;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] src_data [NCH];
    logic [NCH-1:0]   src_valid;
    bit               hold_src;
    bit               auto_src;

    int m_valid, m_data, m_ch, m_ptr;

    mux_n1_stream #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    always #5 clk = ~clk;

    always_comb begin
        in_data  = '0;
        in_valid = src_valid;
        for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = src_data[i];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: predict handshakes at the negedge, compare, then advance the model past the edge.
    task automatic step();
        int cand;
        int gv;
        int ld;
        int space;
        int exp_rdy;
        @(negedge clk);
        cand = 0;
        gv   = 0;
        if (mode == MODE_MANUAL) begin
            cand = int'(sel);
            gv   = (cand < NCH && src_valid[cand]) ? 1 : 0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (gv == 0 && src_valid[c]) begin
                    cand = c;
                    gv   = 1;
                end
            end
        end
        space   = (m_valid == 0 || out_ready) ? 1 : 0;
        ld      = (!rst && space != 0 && gv != 0) ? 1 : 0;
        exp_rdy = (ld != 0) ? (1 << cand) : 0;

        chk("in_ready",  32'(in_ready),  32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_ch",    32'(out_ch),    32'(m_ch));

        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
        end else if (ld != 0) begin
            m_valid = 1;
            m_data  = int'(src_data[cand]);
            m_ch    = cand;
            if (mode == MODE_SCAN) m_ptr = (cand + 1) % NCH;
        end else if (m_valid != 0 && out_ready) begin
            m_valid = 0;
        end

        if (ld != 0 && !hold_src) src_valid[cand] = 1'b0;
        if (auto_src) begin
            for (int i = 0; i < NCH; i++) begin
                if (!src_valid[i] && $urandom_range(0, 2) == 0) begin
                    src_valid[i] = 1'b1;
                    src_data[i]  = WIDTH'($urandom);
                end
            end
        end
    endtask

    task automatic drain();
        src_valid = '0;
        out_ready = 1'b1;
        step();
        step();
    endtask

    initial begin
        logic [SEL_W-1:0] rr_seq [6];
        rr_seq = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
        hold_src  = 1'b0;
        auto_src  = 1'b0;
        rst       = 1'b1;
        mode      = MODE_MANUAL;
        sel       = '0;
        out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) src_data[i] = WIDTH'(8'h10 + i);
        src_valid = '1;

        // Reset held with every channel requesting
        #1;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'h00);
        chk("rst_out_ch",    32'(out_ch),    32'd0);
        rst = 1'b0;
        step();
        chk("rst_first_load", 32'(out_valid), 32'd1);
        chk("rst_first_data", 32'(out_data),  32'h10);
        drain();

        // Manual select of channel 2
        mode = MODE_MANUAL;
        sel  = 2'd2;
        src_data[2]  = 8'hA5;
        src_valid[2] = 1'b1;
        #1;
        chk("man_in_ready", 32'(in_ready), 32'b0100);
        step();
        chk("man_out_data",  32'(out_data),  32'hA5);
        chk("man_out_ch",    32'(out_ch),    32'd2);
        chk("man_out_valid", 32'(out_valid), 32'd1);
        drain();

        // Round-robin skipping idle channel 2
        hold_src  = 1'b1;
        mode      = MODE_SCAN;
        src_valid = 4'b1011;
        for (int n = 0; n < 6; n++) begin
            step();
            chk($sformatf("rr_ch%0d", n), 32'(out_ch), 32'(rr_seq[n]));
        end
        hold_src = 1'b0;
        mode     = MODE_MANUAL;
        drain();

        // Backpressure while channel 0 waits
        sel          = 2'd1;
        src_data[1]  = 8'h3C;
        src_valid[1] = 1'b1;
        step();
        chk("bp_load", 32'(out_data), 32'h3C);
        sel          = 2'd0;
        src_data[0]  = 8'h5A;
        src_valid[0] = 1'b1;
        out_ready    = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            step();
            chk("bp_hold", 32'(out_data), 32'h3C);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_data",  32'(out_data),  32'h5A);
        chk("bp_release_valid", 32'(out_valid), 32'd1);

        // Manual select of an idle channel
        hold_src  = 1'b1;
        sel       = 2'd1;
        src_valid = 4'b1101;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("idle_pop", 32'(out_valid), 32'd0);
        drain();

        // Reset in the middle of a scan stream
        mode      = MODE_SCAN;
        src_valid = 4'b1111;
        step();
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        step();
        chk("mid_rst_ch0", 32'(out_ch), 32'd0);
        hold_src = 1'b0;

        // Randomized traffic
        auto_src = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0)  sel  = SEL_W'($urandom_range(0, NCH - 1));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
